dominos_input_ctrl: RTL and testbench

//  Player-input front end feeding the dominos core control pins. Takes PS/2 key

---
 rtl/dominos_input_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_dominos_input_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dominos_input_ctrl.sv
// Dominos player-input front end: PS/2 + HPS joysticks to the core's
// active-low control pins, with opposing-direction cancel and coin stretching.
module dominos_input_ctrl #(
  parameter int            CW         = 20,
  parameter logic [CW-1:0] COIN_PULSE = 20'd600000,
  parameter logic [CW-1:0] COIN_GAP   = 20'd240000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  output logic        coin1_n,
  output logic        coin2_n,
  output logic        start1_n,
  output logic        start2_n,
  output logic        up1_n,
  output logic        down1_n,
  output logic        left1_n,
  output logic        right1_n,
  output logic        up2_n,
  output logic        down2_n,
  output logic        left2_n,
  output logic        right2_n
);

  typedef enum logic [1:0] {
    C_IDLE,
    C_PULSE,
    C_GAP
  } coin_st_e;

  localparam int K_UP = 0;
  localparam int K_DN = 1;
  localparam int K_LT = 2;
  localparam int K_RT = 3;
  localparam int K_C1 = 4;
  localparam int K_C2 = 5;
  localparam int K_S1 = 6;
  localparam int K_S2 = 7;

  logic [10:0]   ps2_s1_q, ps2_s2_q;
  logic [6:0]    j0_s1_q, j0_s2_q;
  logic [6:0]    j1_s1_q, j1_s2_q;
  logic          tog_old_q, primed_q;
  logic          evt;
  logic [7:0]    key_q, key_d;
  logic [3:0]    dir1, dir2;
  logic [3:0]    dir1_n_d, dir1_n_q;
  logic [3:0]    dir2_n_d, dir2_n_q;
  logic [1:0]    start_n_d, start_n_q;
  logic [1:0]    creq, creq_q;
  logic [1:0]    coin_n_d, coin_n_q;
  coin_st_e      st_q  [2];
  coin_st_e      st_d  [2];
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];

  logic unused_joy;
  assign unused_joy = ^{joystick_0[15:7], joystick_1[15:7]};

  // Direction nibbles are {U,D,L,R}, matching joystick bits [3:0].
  function automatic logic [3:0] resolve(input logic [3:0] d);
    resolve[3] = d[3] & ~d[2];
    resolve[2] = d[2] & ~d[3];
    resolve[1] = d[1] & ~d[0];
    resolve[0] = d[0] & ~d[1];
  endfunction

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ps2_s1_q  <= '0;
      ps2_s2_q  <= '0;
      j0_s1_q   <= '0;
      j0_s2_q   <= '0;
      j1_s1_q   <= '0;
      j1_s2_q   <= '0;
      tog_old_q <= 1'b0;
      primed_q  <= 1'b0;
      key_q     <= '0;
    end else begin
      ps2_s1_q  <= ps2_key;
      ps2_s2_q  <= ps2_s1_q;
      j0_s1_q   <= joystick_0[6:0];
      j0_s2_q   <= j0_s1_q;
      j1_s1_q   <= joystick_1[6:0];
      j1_s2_q   <= j1_s1_q;
      tog_old_q <= ps2_s2_q[10];
      primed_q  <= 1'b1;
      key_q     <= key_d;
    end
  end

  always_comb begin
    key_d = key_q;
    evt   = primed_q && (ps2_s2_q[10] != tog_old_q);
    if (evt) begin
      unique case (1'b1)
        ps2_s2_q[7:0] == 8'h75:  key_d[K_UP] = ps2_s2_q[9];
        ps2_s2_q[7:0] == 8'h72:  key_d[K_DN] = ps2_s2_q[9];
        ps2_s2_q[7:0] == 8'h6B:  key_d[K_LT] = ps2_s2_q[9];
        ps2_s2_q[7:0] == 8'h74:  key_d[K_RT] = ps2_s2_q[9];
        ps2_s2_q[8:0] == 9'h029: key_d[K_C1] = ps2_s2_q[9];
        ps2_s2_q[8:0] == 9'h014: key_d[K_C2] = ps2_s2_q[9];
        ps2_s2_q[8:0] == 9'h005: key_d[K_S1] = ps2_s2_q[9];
        ps2_s2_q[8:0] == 9'h006: key_d[K_S2] = ps2_s2_q[9];
        default: ;
      endcase
    end
  end

  always_comb begin
    dir1 = {key_q[K_UP], key_q[K_DN], key_q[K_LT], key_q[K_RT]}
         | j0_s2_q[3:0];
    dir2 = j1_s2_q[3:0];
    dir1_n_d = ~resolve(dir1);
    dir2_n_d = ~resolve(dir2);
    start_n_d[0] = ~(key_q[K_S1] | j0_s2_q[5] | j1_s2_q[5]);
    start_n_d[1] = ~(key_q[K_S2] | j0_s2_q[6] | j1_s2_q[6]);
    creq[0] = key_q[K_C1] | j0_s2_q[4];
    creq[1] = key_q[K_C2] | j1_s2_q[4];
  end

  // Edges arriving outside IDLE are dropped; creq_q still tracks every cycle.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      unique case (st_q[i])
        C_IDLE: begin
          if (creq[i] && !creq_q[i]) begin
            st_d[i]  = C_PULSE;
            cnt_d[i] = COIN_PULSE - 1'b1;
          end
        end
        C_PULSE: begin
          if (cnt_q[i] == '0) begin
            if (COIN_GAP == '0) begin
              st_d[i] = C_IDLE;
            end else begin
              st_d[i]  = C_GAP;
              cnt_d[i] = COIN_GAP - 1'b1;
            end
          end else begin
            cnt_d[i] = cnt_q[i] - 1'b1;
          end
        end
        C_GAP: begin
          if (cnt_q[i] == '0) begin
            st_d[i] = C_IDLE;
          end else begin
            cnt_d[i] = cnt_q[i] - 1'b1;
          end
        end
        default: st_d[i] = C_IDLE;
      endcase
      coin_n_d[i] = (st_d[i] != C_PULSE);
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        st_q[i]  <= C_IDLE;
        cnt_q[i] <= '0;
      end
      creq_q    <= '0;
      coin_n_q  <= 2'b11;
      start_n_q <= 2'b11;
      dir1_n_q  <= 4'hF;
      dir2_n_q  <= 4'hF;
    end else begin
      for (int i = 0; i < 2; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      creq_q    <= creq;
      coin_n_q  <= coin_n_d;
      start_n_q <= start_n_d;
      dir1_n_q  <= dir1_n_d;
      dir2_n_q  <= dir2_n_d;
    end
  end

  assign coin1_n  = coin_n_q[0];
  assign coin2_n  = coin_n_q[1];
  assign start1_n = start_n_q[0];
  assign start2_n = start_n_q[1];
  assign up1_n    = dir1_n_q[3];
  assign down1_n  = dir1_n_q[2];
  assign left1_n  = dir1_n_q[1];
  assign right1_n = dir1_n_q[0];
  assign up2_n    = dir2_n_q[3];
  assign down2_n  = dir2_n_q[2];
  assign left2_n  = dir2_n_q[1];
  assign right2_n = dir2_n_q[0];

endmodule

// File: tb/tb_dominos_input_ctrl.sv
// Directed bench for dominos_input_ctrl: key decode, latency,
// direction cancel, coin stretch/lockout and async reset.
module tb_dominos_input_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic [15:0] j0, j1;
  logic coin1_n, coin2_n, start1_n, start2_n;
  logic up1_n, down1_n, left1_n, right1_n;
  logic up2_n, down2_n, left2_n, right2_n;
  logic [11:0] outs;

  int n_chk  = 0;
  int n_pass = 0;
  int first, low;

  always #5 clk = ~clk;

  dominos_input_ctrl #(
    .CW(20),
    .COIN_PULSE(20'd8),
    .COIN_GAP(20'd4)
  ) dut (
    .clk_sys(clk),
    .reset(reset),
    .ps2_key(ps2_key),
    .joystick_0(j0),
    .joystick_1(j1),
    .coin1_n(coin1_n),
    .coin2_n(coin2_n),
    .start1_n(start1_n),
    .start2_n(start2_n),
    .up1_n(up1_n),
    .down1_n(down1_n),
    .left1_n(left1_n),
    .right1_n(right1_n),
    .up2_n(up2_n),
    .down2_n(down2_n),
    .left2_n(left2_n),
    .right2_n(right2_n)
  );

  assign outs = {coin1_n, coin2_n, start1_n, start2_n,
                 up1_n, down1_n, left1_n, right1_n,
                 up2_n, down2_n, left2_n, right2_n};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic key(input logic pr, input logic [8:0] code);
    ps2_key = {~ps2_key[10], pr, code};
  endtask

  // Count coin1 low cycles over n ticks, noting the first low tick.
  task automatic watch_coin(input int n);
    first = -1;
    low   = 0;
    for (int i = 1; i <= n; i++) begin
      tick(1);
      if (!coin1_n) begin
        low++;
        if (first < 0) first = i;
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    ps2_key = 11'h600;
    j0      = '0;
    j1      = '0;
    tick(3);
    chk("rst_outs", outs, 12'hFFF);
    reset = 1'b0;
    tick(6);
    chk("post_rst", outs, 12'hFFF);

    key(1'b1, 9'h075);
    tick(3);
    chk("up1_lat3", up1_n, 1);
    tick(1);
    chk("up1_press", up1_n, 0);
    key(1'b1, 9'h175);
    tick(4);
    chk("up1_ext", up1_n, 0);
    key(1'b0, 9'h075);
    tick(4);
    chk("up1_rel", up1_n, 1);

    j0 = 16'h0010;
    watch_coin(50);
    chk("coin_first", first, 3);
    chk("coin_len", low, 8);
    j0 = '0;
    tick(5);

    j0  = 16'h0010;
    low = 0;
    for (int i = 1; i <= 30; i++) begin
      tick(1);
      if (!coin1_n) low++;
      if (i == 6) j0 = '0;
      if (i == 9) j0 = 16'h0010;
    end
    chk("coin_gap_drop", low, 8);
    j0 = '0;
    tick(3);
    j0 = 16'h0010;
    watch_coin(20);
    chk("repress_first", first, 3);
    chk("repress_len", low, 8);
    j0 = '0;
    tick(20);

    j0 = 16'h000E;
    key(1'b1, 9'h029);
    tick(3);
    chk("ud_cancel", {up1_n, down1_n}, 2'b11);
    chk("left_joy", {left1_n, right1_n}, 2'b01);
    chk("space_lat3", coin1_n, 1);
    tick(1);
    chk("space_coin", coin1_n, 0);
    key(1'b1, 9'h074);
    tick(4);
    chk("lr_cancel", {left1_n, right1_n}, 2'b11);
    chk("ud_still", {up1_n, down1_n}, 2'b11);
    j0 = 16'h0004;
    tick(3);
    chk("down_right", {up1_n, down1_n, left1_n, right1_n}, 4'b1010);
    key(1'b0, 9'h074);
    tick(4);
    key(1'b0, 9'h029);
    tick(4);
    j0 = '0;
    tick(20);
    chk("dirs_idle", outs, 12'hFFF);

    j0 = 16'h0010;
    tick(5);
    chk("mid_pulse", coin1_n, 0);
    reset = 1'b1;
    #1;
    chk("rst_cut", coin1_n, 1);
    j0 = '0;
    tick(2);
    reset = 1'b0;
    tick(6);
    chk("rst_idle", outs, 12'hFFF);
    j0 = 16'h0010;
    tick(3);
    chk("post_rst_pulse", coin1_n, 0);
    j0 = '0;
    tick(20);

    key(1'b1, 9'h005);
    j1 = 16'h0040;
    tick(3);
    chk("start2_joy", start2_n, 0);
    chk("start1_lat3", start1_n, 1);
    tick(1);
    chk("start1_key", start1_n, 0);
    j1 = 16'h0043;
    tick(3);
    chk("p2_lr_cancel", {left2_n, right2_n}, 2'b11);
    chk("start2_held", start2_n, 0);
    j1 = 16'h0009;
    tick(3);
    chk("p2_up_right", {up2_n, down2_n, left2_n, right2_n}, 4'b0110);
    chk("starts", {start1_n, start2_n}, 2'b01);
    key(1'b1, 9'h014);
    tick(4);
    chk("coin2_ctrl", coin2_n, 0);
    chk("coin1_quiet", coin1_n, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
